lisp_stack_cache: RTL and testbench



---
 rtl/lisp_stack_cache_pkg.sv | 34 +++
 rtl/lisp_stack_cache_if.sv | 14 +
 rtl/lisp_stack_cache_regs.sv | 76 +++++++
 rtl/lisp_stack_cache.sv | 228 ++++++++++++++++++++++
 tb/tb_lisp_stack_cache.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lisp_stack_cache_pkg.sv
// Shared types for the Lisp top-of-stack cache: word layout, stack command
// encodings, controller states and a helper giving the entries an op needs.
package lisp_stack_cache_pkg;

    localparam int unsigned VALUE_WIDTH = 16;
    localparam int unsigned TAG_WIDTH   = 4;
    localparam int unsigned WORD_SIZE   = VALUE_WIDTH + TAG_WIDTH;

    typedef enum logic [1:0] {
        STACK_PUSH        = 2'd0,
        STACK_POP         = 2'd1,
        STACK_REPLACE     = 2'd2,
        STACK_POP_REPLACE = 2'd3
    } stack_op_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SPILL      = 3'd1,
        ST_FILL_ISSUE = 3'd2,
        ST_FILL_WAIT  = 3'd3,
        ST_FLUSH      = 3'd4,
        ST_FLUSH_DONE = 3'd5
    } cache_state_e;

    // Number of live stack entries an op must see before it can run.
    function automatic logic [1:0] op_need(input stack_op_e op);
        case (op)
            STACK_PUSH:        return 2'd0;
            STACK_POP_REPLACE: return 2'd2;
            default:           return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/lisp_stack_cache_if.sv
// Core-side command handshake of the stack cache.
//   master: core datapath (drives cmd_valid/cmd_op/cmd_data)
//   slave : stack cache   (drives cmd_ready)
interface lisp_stack_cache_if;
    import lisp_stack_cache_pkg::*;

    logic                 cmd_valid;
    stack_op_e            cmd_op;
    logic [WORD_SIZE-1:0] cmd_data;
    logic                 cmd_ready;

    modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/lisp_stack_cache_regs.sv
// DEPTH-entry shift array holding the cached top of stack.
// Entry 0 is the top; entry count-1 is the oldest (bottom) cached word.
// Entries at index >= count are kept at zero, so tos/nos read straight
// from registers and are 0 when not valid.
//   push/pop/replace : core ops (pop+replace together = POP_REPLACE)
//   insert_bottom    : append fill_data below the oldest entry
//   remove_bottom    : drop the oldest entry (after it was spilled)
//   tos/nos          : entries 0/1; bottom/bottom2: entries count-1/count-2
module lisp_stack_cache_regs
    import lisp_stack_cache_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 replace,
    input  logic                 insert_bottom,
    input  logic                 remove_bottom,
    input  logic [WORD_SIZE-1:0] push_data,
    input  logic [WORD_SIZE-1:0] fill_data,
    output logic [WORD_SIZE-1:0] tos,
    output logic [WORD_SIZE-1:0] nos,
    output logic [WORD_SIZE-1:0] bottom,
    output logic [WORD_SIZE-1:0] bottom2,
    output logic [CW-1:0]        count
);

    logic [WORD_SIZE-1:0] entry_q [DEPTH];
    logic [CW-1:0]        count_q;

    // Entry array and occupancy update; one control is active per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            count_q <= '0;
        end else if (push) begin
            entry_q[0] <= push_data;
            for (int i = 1; i < DEPTH; i++) entry_q[i] <= entry_q[i-1];
            count_q <= count_q + CW'(1);
        end else if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) entry_q[i] <= entry_q[i+1];
            entry_q[DEPTH-1] <= '0;
            // POP_REPLACE: the old NOS is overwritten by the new value.
            if (replace) entry_q[0] <= push_data;
            count_q <= count_q - CW'(1);
        end else if (replace) begin
            entry_q[0] <= push_data;
        end else if (insert_bottom) begin
            for (int i = 0; i < DEPTH; i++)
                if (CW'(i) == count_q) entry_q[i] <= fill_data;
            count_q <= count_q + CW'(1);
        end else if (remove_bottom) begin
            for (int i = 0; i < DEPTH; i++)
                if (CW'(i + 1) == count_q) entry_q[i] <= '0;
            count_q <= count_q - CW'(1);
        end
    end

    // Oldest and second-oldest cached entries, selected by occupancy.
    always_comb begin
        bottom  = '0;
        bottom2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == count_q) bottom  = entry_q[i];
            if (CW'(i + 2) == count_q) bottom2 = entry_q[i];
        end
    end

    assign tos   = entry_q[0];
    assign nos   = entry_q[1];
    assign count = count_q;

endmodule

// File: rtl/lisp_stack_cache.sv
// Top-of-stack cache: keeps the top DEPTH stack words in registers, spills
// the oldest to memory when full, refills on demand or in the background,
// and can flush everything to memory. Memory stack grows down from STACK_TOP.
//   clk, reset        : clock, synchronous active-high reset
//   cmd (slave)       : cmd_valid/cmd_op/cmd_data in, cmd_ready out
//   flush/flush_done  : flush request pulse / completion pulse
//   tos/nos(+_valid)  : top two stack words
//   stack_pointer     : logical SP (memory SP minus cached count)
//   stack_error       : sticky underflow flag
//   mem_*             : synchronous memory port (read data one cycle late)
module lisp_stack_cache
    import lisp_stack_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STACK_TOP  = 8184,
    parameter int unsigned FILL_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    lisp_stack_cache_if.slave     cmd,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [WORD_SIZE-1:0]  tos,
    output logic [WORD_SIZE-1:0]  nos,
    output logic                  tos_valid,
    output logic                  nos_valid,
    output logic [ADDR_WIDTH-1:0] stack_pointer,
    output logic                  stack_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    output logic [WORD_SIZE-1:0]  mem_write_value,
    input  logic [WORD_SIZE-1:0]  mem_read_value
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CWX = CW + 1;
    localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]         FILL_C    = CW'(FILL_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] STACK_TOP_A = ADDR_WIDTH'(STACK_TOP);

    cache_state_e          state_q;
    logic [ADDR_WIDTH-1:0] mem_sp_q;
    logic [ADDR_WIDTH-1:0] sp_q;
    logic                  stack_error_q;
    logic                  flush_done_q;
    logic                  mem_we_q;
    logic                  mem_re_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WORD_SIZE-1:0]  mem_wdata_q;

    logic [WORD_SIZE-1:0]  bottom;
    logic [WORD_SIZE-1:0]  bottom2;
    logic [CW-1:0]         count;

    logic       cmd_ready_c;
    logic       do_push, do_pop, do_replace, do_insert, do_remove;
    logic       take_flush, take_cmd, start_spill, start_fill, flag_error;
    logic       satisfiable, mem_has;
    logic [1:0] mem_avail;

    lisp_stack_cache_regs #(.DEPTH(DEPTH)) u_regs (
        .clk           (clk),
        .reset         (reset),
        .push          (do_push),
        .pop           (do_pop),
        .replace       (do_replace),
        .insert_bottom (do_insert),
        .remove_bottom (do_remove),
        .push_data     (cmd.cmd_data),
        .fill_data     (mem_read_value),
        .tos           (tos),
        .nos           (nos),
        .bottom        (bottom),
        .bottom2       (bottom2),
        .count         (count)
    );

    // IDLE decision (flush > command > background fill) and array controls.
    always_comb begin
        cmd_ready_c = 1'b0;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        do_replace  = 1'b0;
        do_insert   = 1'b0;
        do_remove   = 1'b0;
        take_flush  = 1'b0;
        take_cmd    = 1'b0;
        start_spill = 1'b0;
        start_fill  = 1'b0;
        flag_error  = 1'b0;

        mem_has = (mem_sp_q < STACK_TOP_A);
        // Memory-resident entries, saturated at 2 (the most any op needs).
        if (!mem_has)                                    mem_avail = 2'd0;
        else if (mem_sp_q == STACK_TOP_A - ADDR_WIDTH'(1)) mem_avail = 2'd1;
        else                                             mem_avail = 2'd2;

        case (cmd.cmd_op)
            STACK_PUSH:                satisfiable = (count < DEPTH_C);
            STACK_POP, STACK_REPLACE:  satisfiable = (count != '0);
            default:                   satisfiable = (count >= CW'(2));
        endcase

        if (state_q == ST_IDLE && !reset) begin
            if (flush) begin
                take_flush = 1'b1;
            end else if (cmd.cmd_valid) begin
                if (satisfiable) begin
                    cmd_ready_c = 1'b1;
                    take_cmd    = 1'b1;
                    case (cmd.cmd_op)
                        STACK_PUSH:    do_push    = 1'b1;
                        STACK_POP:     do_pop     = 1'b1;
                        STACK_REPLACE: do_replace = 1'b1;
                        default: begin
                            do_pop     = 1'b1;
                            do_replace = 1'b1;
                        end
                    endcase
                end else if (cmd.cmd_op == STACK_PUSH) begin
                    start_spill = 1'b1;
                end else if ((CWX'(count) + CWX'(mem_avail)) < CWX'(op_need(cmd.cmd_op))) begin
                    // Underflow: swallow the op, leave the stack untouched.
                    cmd_ready_c = 1'b1;
                    flag_error  = 1'b1;
                end else begin
                    start_fill = 1'b1;
                end
            end else if (count < FILL_C && mem_has) begin
                start_fill = 1'b1;
            end
        end

        if (state_q == ST_FILL_WAIT) do_insert = 1'b1;
        if (state_q == ST_SPILL || (state_q == ST_FLUSH && count != '0)) do_remove = 1'b1;
    end

    // Controller FSM with registered memory strobes and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_sp_q      <= STACK_TOP_A;
            sp_q          <= STACK_TOP_A;
            stack_error_q <= 1'b0;
            flush_done_q  <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            flush_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take_flush) begin
                        state_q <= ST_FLUSH;
                        if (count != '0) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= mem_sp_q - ADDR_WIDTH'(1);
                            mem_wdata_q <= bottom;
                        end
                    end else if (take_cmd) begin
                        if (cmd.cmd_op == STACK_PUSH)
                            sp_q <= sp_q - ADDR_WIDTH'(1);
                        else if (cmd.cmd_op != STACK_REPLACE)
                            sp_q <= sp_q + ADDR_WIDTH'(1);
                    end else if (flag_error) begin
                        stack_error_q <= 1'b1;
                    end else if (start_spill) begin
                        state_q     <= ST_SPILL;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= mem_sp_q - ADDR_WIDTH'(1);
                        mem_wdata_q <= bottom;
                    end else if (start_fill) begin
                        state_q    <= ST_FILL_ISSUE;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= mem_sp_q;
                    end
                end
                ST_SPILL: begin
                    mem_sp_q <= mem_sp_q - ADDR_WIDTH'(1);
                    state_q  <= ST_IDLE;
                end
                ST_FILL_ISSUE: begin
                    state_q <= ST_FILL_WAIT;
                end
                ST_FILL_WAIT: begin
                    mem_sp_q <= mem_sp_q + ADDR_WIDTH'(1);
                    state_q  <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (count != '0) mem_sp_q <= mem_sp_q - ADDR_WIDTH'(1);
                    // Queue the next-oldest entry while one remains after this write.
                    if (count > CW'(1)) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= mem_sp_q - ADDR_WIDTH'(2);
                        mem_wdata_q <= bottom2;
                    end else begin
                        state_q      <= ST_FLUSH_DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                ST_FLUSH_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are masked during reset so an aborted spill/fill never reaches memory.
    assign cmd.cmd_ready      = cmd_ready_c;
    assign flush_done         = flush_done_q & ~reset;
    assign mem_write_enable   = mem_we_q & ~reset;
    assign mem_read_enable    = mem_re_q & ~reset;
    assign mem_addr           = mem_addr_q;
    assign mem_write_value    = mem_wdata_q;
    assign tos_valid          = (count != '0);
    assign nos_valid          = (count >= CW'(2));
    assign stack_pointer      = sp_q;
    assign stack_error        = stack_error_q;

endmodule

// File: tb/tb_lisp_stack_cache.sv
// Self-checking bench for lisp_stack_cache: directed scenarios followed by
// random command/flush traffic checked against a queue model of the stack.
module tb_lisp_stack_cache;
    import lisp_stack_cache_pkg::*;

    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned STOP  = 8184;
    localparam int unsigned FILL  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 flush_done;
    logic [WORD_SIZE-1:0] tos, nos;
    logic                 tos_valid, nos_valid;
    logic [AW-1:0]        stack_pointer;
    logic                 stack_error;
    logic [AW-1:0]        mem_addr;
    logic                 mem_write_enable, mem_read_enable;
    logic [WORD_SIZE-1:0] mem_write_value;
    logic [WORD_SIZE-1:0] mem_read_value;

    lisp_stack_cache_if cmd_if ();

    lisp_stack_cache #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .STACK_TOP(STOP), .FILL_LEVEL(FILL)) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd              (cmd_if),
        .flush            (flush),
        .flush_done       (flush_done),
        .tos              (tos),
        .nos              (nos),
        .tos_valid        (tos_valid),
        .nos_valid        (nos_valid),
        .stack_pointer    (stack_pointer),
        .stack_error      (stack_error),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_value  (mem_write_value),
        .mem_read_value   (mem_read_value)
    );

    always #5 clk = ~clk;

    // Synchronous memory with a write log and read counter.
    logic [WORD_SIZE-1:0] mem [65536];
    logic [AW-1:0]        wr_addr_log [$];
    logic [WORD_SIZE-1:0] wr_data_log [$];
    int unsigned          rd_cnt = 0;
    logic [AW-1:0]        last_rd_addr = '0;

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_addr] <= mem_write_value;
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_write_value);
        end
        if (mem_read_enable) begin
            mem_read_value <= mem[mem_addr];
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= mem_addr;
        end
    end

    // Reference model: whole logical stack, top at index 0.
    logic [WORD_SIZE-1:0] stk [$];
    logic                 model_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          last_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_apply(input stack_op_e op, input logic [WORD_SIZE-1:0] d);
        int need;
        need = (op == STACK_PUSH) ? 0 : (op == STACK_POP_REPLACE) ? 2 : 1;
        if (need > stk.size()) begin
            model_err = 1'b1;
        end else begin
            case (op)
                STACK_PUSH:    stk.push_front(d);
                STACK_POP:     void'(stk.pop_front());
                STACK_REPLACE: stk[0] = d;
                default: begin
                    void'(stk.pop_front());
                    stk[0] = d;
                end
            endcase
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic do_cmd(input stack_op_e op, input logic [WORD_SIZE-1:0] d);
        int waited = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = d;
        #1;
        while (!cmd_if.cmd_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        last_wait = waited;
        if (waited >= 20) begin
            check("cmd_timeout", 32'(waited), 32'(0));
            @(negedge clk);
            cmd_if.cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_apply(op, d);
            @(negedge clk);
            cmd_if.cmd_valid = 1'b0;
        end
    endtask

    task automatic check_view(input string tag);
        check({tag, "_err"}, 32'(stack_error), 32'(model_err));
        check({tag, "_sp"}, 32'(stack_pointer), 32'(AW'(STOP - stk.size())));
        check({tag, "_tosv_bound"}, 32'(tos_valid && stk.size() < 1), 32'(0));
        check({tag, "_nosv_bound"}, 32'(nos_valid && stk.size() < 2), 32'(0));
        check({tag, "_tos"}, 32'(tos), 32'((tos_valid && stk.size() >= 1) ? stk[0] : '0));
        check({tag, "_nos"}, 32'(nos), 32'((nos_valid && stk.size() >= 2) ? stk[1] : '0));
    endtask

    // Let background fills settle, flush, then verify memory holds the whole stack.
    task automatic do_flush(input string tag);
        int waited = 0;
        logic [AW-1:0] sp;
        repeat (8) @(negedge clk);
        check({tag, "_settled_tosv"}, 32'(tos_valid), 32'(stk.size() >= 1));
        check({tag, "_settled_nosv"}, 32'(nos_valid), 32'(stk.size() >= 2));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        while (!flush_done && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_done_seen"}, 32'(flush_done), 32'(1));
        check({tag, "_empty"}, 32'(tos_valid), 32'(0));
        check({tag, "_sp"}, 32'(stack_pointer), 32'(AW'(STOP - stk.size())));
        sp = AW'(STOP - stk.size());
        for (int k = 0; k < stk.size(); k++)
            check({tag, "_mem"}, 32'(mem[AW'(sp + AW'(k))]), 32'(stk[k]));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(flush_done), 32'(0));
    endtask

    task automatic apply_reset();
        reset            = 1'b1;
        flush            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        stk.delete();
        model_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, rb, r;
        stack_op_e op;

        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem_read_value = '0;
        cmd_if.cmd_data = '0;
        cmd_if.cmd_op   = STACK_PUSH;

        // Reset values, with a push pending during reset.
        reset = 1'b1;
        flush = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        #1;
        check("ready_in_reset", 32'(cmd_if.cmd_ready), 32'(0));
        repeat (2) @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        reset = 1'b0;
        stk.delete();
        model_err = 1'b0;
        check("rst_tos", 32'(tos), 32'(0));
        check("rst_nos", 32'(nos), 32'(0));
        check("rst_tosv", 32'(tos_valid), 32'(0));
        check("rst_sp", 32'(stack_pointer), 32'(STOP));
        check("rst_err", 32'(stack_error), 32'(0));
        check("rst_fdone", 32'(flush_done), 32'(0));
        check("rst_we", 32'(mem_write_enable), 32'(0));
        check("rst_re", 32'(mem_read_enable), 32'(0));

        // PUSH 1..5: fifth push spills word 1 to 8183.
        wb = wr_addr_log.size();
        for (int v = 1; v <= 5; v++) do_cmd(STACK_PUSH, WORD_SIZE'(v));
        check("full_push_latency", 32'(last_wait), 32'(2));
        check("spill_count", 32'(wr_addr_log.size() - wb), 32'(1));
        check("spill_addr", 32'(wr_addr_log[wb]), 32'(8183));
        check("spill_data", 32'(wr_data_log[wb]), 32'(1));
        check("push5_tos", 32'(tos), 32'(5));
        check("push5_nos", 32'(nos), 32'(4));
        check("push5_sp", 32'(stack_pointer), 32'(8179));

        // POP x4 then idle: background fill brings word 1 back from 8183.
        rb = rd_cnt;
        for (int i = 0; i < 4; i++) do_cmd(STACK_POP, '0);
        repeat (10) @(negedge clk);
        check("refill_reads", 32'(rd_cnt - rb), 32'(1));
        check("refill_addr", 32'(last_rd_addr), 32'(8183));
        check("refill_tos", 32'(tos), 32'(1));
        check("refill_tosv", 32'(tos_valid), 32'(1));
        check("refill_nosv", 32'(nos_valid), 32'(0));
        check("refill_sp", 32'(stack_pointer), 32'(8183));

        // Underflow: POP on an empty stack is swallowed and flags an error.
        do_cmd(STACK_POP, '0);
        do_cmd(STACK_POP, '0);
        check("uflow_ready_now", 32'(last_wait), 32'(0));
        check("uflow_err", 32'(stack_error), 32'(1));
        check("uflow_tosv", 32'(tos_valid), 32'(0));
        check("uflow_sp", 32'(stack_pointer), 32'(STOP));
        do_cmd(STACK_PUSH, WORD_SIZE'(7));
        check("after_uflow_tos", 32'(tos), 32'(7));
        check("err_sticky", 32'(stack_error), 32'(1));

        // PUSH 3, PUSH 4, POP_REPLACE 12: pure cache operation.
        apply_reset();
        wb = wr_addr_log.size();
        rb = rd_cnt;
        do_cmd(STACK_PUSH, WORD_SIZE'(3));
        do_cmd(STACK_PUSH, WORD_SIZE'(4));
        do_cmd(STACK_POP_REPLACE, WORD_SIZE'(12));
        check("poprep_tos", 32'(tos), 32'(12));
        check("poprep_tosv", 32'(tos_valid), 32'(1));
        check("poprep_nosv", 32'(nos_valid), 32'(0));
        check("poprep_sp", 32'(stack_pointer), 32'(8183));
        check("poprep_no_wr", 32'(wr_addr_log.size() - wb), 32'(0));
        check("poprep_no_rd", 32'(rd_cnt - rb), 32'(0));

        // Flush of three cached words, oldest first.
        do_cmd(STACK_PUSH, WORD_SIZE'(20));
        do_cmd(STACK_PUSH, WORD_SIZE'(21));
        wb = wr_addr_log.size();
        do_flush("flush3");
        check("flush3_nwr", 32'(wr_addr_log.size() - wb), 32'(3));
        check("flush3_a0", 32'(wr_addr_log[wb]), 32'(8183));
        check("flush3_d0", 32'(wr_data_log[wb]), 32'(12));
        check("flush3_a1", 32'(wr_addr_log[wb+1]), 32'(8182));
        check("flush3_d1", 32'(wr_data_log[wb+1]), 32'(20));
        check("flush3_a2", 32'(wr_addr_log[wb+2]), 32'(8181));
        check("flush3_d2", 32'(wr_data_log[wb+2]), 32'(21));

        // Reset while a spill is in progress.
        apply_reset();
        for (int v = 1; v <= 4; v++) do_cmd(STACK_PUSH, WORD_SIZE'(v));
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = STACK_PUSH;
        cmd_if.cmd_data  = WORD_SIZE'(5);
        @(negedge clk);
        check("spill_active", 32'(mem_write_enable), 32'(1));
        wb = wr_addr_log.size();
        reset = 1'b1;
        #1;
        check("spill_rst_we", 32'(mem_write_enable), 32'(0));
        check("spill_rst_ready", 32'(cmd_if.cmd_ready), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        stk.delete();
        model_err = 1'b0;
        check("spill_rst_nowr", 32'(wr_addr_log.size() - wb), 32'(0));
        check("spill_rst_tos", 32'(tos), 32'(0));
        check("spill_rst_tosv", 32'(tos_valid), 32'(0));
        check("spill_rst_sp", 32'(stack_pointer), 32'(STOP));
        check("spill_rst_we2", 32'(mem_write_enable), 32'(0));
        check("spill_rst_re", 32'(mem_read_enable), 32'(0));

        // Random traffic against the queue model.
        apply_reset();
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                do_flush("rnd_flush");
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 42)      op = STACK_PUSH;
                else if (r < 65) op = STACK_POP;
                else if (r < 80) op = STACK_REPLACE;
                else             op = STACK_POP_REPLACE;
                do_cmd(op, WORD_SIZE'($urandom));
                check_view("rnd");
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        do_flush("final_flush");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
